// File: rtl/meter_pkg.sv
// Shared types and helpers for the stereo level-meter frame scheduler.
package meter_pkg;

  // Frame scheduler phases
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPDATE  = 2'd1,
    ST_COMPOSE = 2'd2,
    ST_OFFER   = 2'd3
  } meter_state_e;

  // Bits needed to hold values 0..max_value (never less than one bit)
  function automatic int unsigned bits_for(input int unsigned max_value);
    int unsigned w;
    w = $clog2(max_value + 1);
    return (w == 0) ? 1 : w;
  endfunction

  // Width of a per-channel LED count (0..leds)
  function automatic int unsigned meter_cw(input int unsigned leds);
    return bits_for(leds);
  endfunction

  // Top bits of the level become the LED count, clipped to the bar length
  function automatic logic [31:0] level_to_count(input logic [31:0] level,
                                                 input int unsigned shift,
                                                 input int unsigned leds);
    logic [31:0] n;
    n = level >> shift;
    if (n > 32'(leds)) n = 32'(leds);
    return n;
  endfunction

endpackage

// File: rtl/meter_channel.sv
// One meter channel: bar with stepped decay plus a held, falling peak dot.
module meter_channel
  import meter_pkg::*;
#(
  parameter int unsigned LEDS             = 16,
  parameter int unsigned LEVEL_WIDTH      = 16,
  parameter int unsigned PEAK_HOLD_FRAMES = 50,
  parameter int unsigned DECAY_FRAMES     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   accept_i,
  input  logic [LEVEL_WIDTH-1:0] level_i,
  input  logic                   update_i,
  output logic [LEDS-1:0]        pattern_o
);

  localparam int unsigned CW    = meter_cw(LEDS);
  localparam int unsigned SHIFT = LEVEL_WIDTH - CW;
  localparam int unsigned HW    = bits_for(PEAK_HOLD_FRAMES);
  localparam int unsigned DW    = bits_for(DECAY_FRAMES - 1);

  localparam logic [HW-1:0] HOLD_INIT  = HW'(PEAK_HOLD_FRAMES);
  localparam logic [DW-1:0] DECAY_LAST = DW'(DECAY_FRAMES - 1);

  logic [CW-1:0] bar_q, bar_d;
  logic [CW-1:0] peak_q, peak_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [DW-1:0] decay_q, decay_d;
  logic          raised_q, raised_d;
  logic          got_q, got_d;

  logic [CW-1:0] level_n;
  logic [CW-1:0] bar_step;
  logic [CW-1:0] peak_m1;

  assign level_n = CW'(level_to_count(32'(level_i), SHIFT, LEDS));

  // Merge accepted levels and apply one frame of ballistics on update
  always_comb begin
    bar_d    = bar_q;
    peak_d   = peak_q;
    hold_d   = hold_q;
    decay_d  = decay_q;
    raised_d = raised_q;
    got_d    = got_q;
    bar_step = bar_q;
    peak_m1  = '0;
    if (accept_i) begin
      if (level_n > bar_q) bar_d = level_n;
      if (level_n > peak_q) begin
        peak_d   = level_n;
        hold_d   = HOLD_INIT;
        raised_d = 1'b1;
      end
      got_d = 1'b1;
    end else if (update_i) begin
      if (got_q) begin
        decay_d = '0;
      end else if (decay_q == DECAY_LAST) begin
        decay_d = '0;
        if (bar_q != '0) bar_step = bar_q - CW'(1);
      end else begin
        decay_d = decay_q + DW'(1);
      end
      bar_d = bar_step;
      // Peak falls toward the already-decayed bar so it never sits below it
      if (!raised_q) begin
        if (hold_q != '0) begin
          hold_d = hold_q - HW'(1);
        end else begin
          peak_m1 = (peak_q != '0) ? peak_q - CW'(1) : '0;
          peak_d  = (peak_m1 > bar_step) ? peak_m1 : bar_step;
        end
      end
      raised_d = 1'b0;
      got_d    = 1'b0;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bar_q    <= '0;
      peak_q   <= '0;
      hold_q   <= '0;
      decay_q  <= '0;
      raised_q <= 1'b0;
      got_q    <= 1'b0;
    end else begin
      bar_q    <= bar_d;
      peak_q   <= peak_d;
      hold_q   <= hold_d;
      decay_q  <= decay_d;
      raised_q <= raised_d;
      got_q    <= got_d;
    end
  end

  // Thermometer bar with the peak dot overlaid
  always_comb begin
    pattern_o = '0;
    for (int unsigned i = 0; i < LEDS; i++) begin
      if (CW'(i) < bar_q) pattern_o[i] = 1'b1;
      if ((peak_q != '0) && (CW'(i) == peak_q - CW'(1))) pattern_o[i] = 1'b1;
    end
  end

endmodule

// File: rtl/meter_frame_scheduler.sv
// Stereo level-meter frame scheduler: refresh divider, frame FSM and shifter handshake.
module meter_frame_scheduler
  import meter_pkg::*;
#(
  parameter int unsigned LEDS             = 16,
  parameter int unsigned LEVEL_WIDTH      = 16,
  parameter int unsigned REFRESH_DIV      = 1000,
  parameter int unsigned PEAK_HOLD_FRAMES = 50,
  parameter int unsigned DECAY_FRAMES     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [LEVEL_WIDTH-1:0] i_left,
  input  logic [LEVEL_WIDTH-1:0] i_right,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [2*LEDS-1:0]      o_data,
  output logic                   o_overrun
);

  localparam int unsigned TW = bits_for(REFRESH_DIV - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(REFRESH_DIV - 1);

  meter_state_e      state_q, state_d;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              tick_pending_q, tick_pending_d;
  logic              overrun_q, overrun_d;
  logic              o_valid_q, o_valid_d;
  logic [2*LEDS-1:0] o_data_q, o_data_d;

  logic              tick_wrap;
  logic              tick_consume;
  logic              accept;
  logic              update_en;
  logic [LEDS-1:0]   left_pattern;
  logic [LEDS-1:0]   right_pattern;

  assign i_ready   = (state_q == ST_IDLE);
  assign accept    = i_valid && i_ready;
  assign o_valid   = o_valid_q;
  assign o_data    = o_data_q;
  assign o_overrun = overrun_q;

  meter_channel #(
    .LEDS             (LEDS),
    .LEVEL_WIDTH      (LEVEL_WIDTH),
    .PEAK_HOLD_FRAMES (PEAK_HOLD_FRAMES),
    .DECAY_FRAMES     (DECAY_FRAMES)
  ) u_left (
    .clk       (clk),
    .reset_n   (reset_n),
    .accept_i  (accept),
    .level_i   (i_left),
    .update_i  (update_en),
    .pattern_o (left_pattern)
  );

  meter_channel #(
    .LEDS             (LEDS),
    .LEVEL_WIDTH      (LEVEL_WIDTH),
    .PEAK_HOLD_FRAMES (PEAK_HOLD_FRAMES),
    .DECAY_FRAMES     (DECAY_FRAMES)
  ) u_right (
    .clk       (clk),
    .reset_n   (reset_n),
    .accept_i  (accept),
    .level_i   (i_right),
    .update_i  (update_en),
    .pattern_o (right_pattern)
  );

  // Free-running refresh divider; a tick arriving while one is still pending is lost
  always_comb begin
    tick_wrap    = (tick_cnt_q == TICK_LAST);
    tick_cnt_d   = tick_wrap ? '0 : tick_cnt_q + TW'(1);
    tick_consume = (state_q == ST_UPDATE);
    // A tick landing in the UPDATE cycle becomes the next pending tick, not an overrun
    tick_pending_d = (tick_pending_q && !tick_consume) || tick_wrap;
    overrun_d      = tick_wrap && tick_pending_q && !tick_consume;
  end

  // Divider, pending-tick and overrun registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q     <= '0;
      tick_pending_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      tick_cnt_q     <= tick_cnt_d;
      tick_pending_q <= tick_pending_d;
      overrun_q      <= overrun_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (tick_pending_q) state_d = ST_UPDATE;
      ST_UPDATE:  state_d = ST_COMPOSE;
      ST_COMPOSE: state_d = ST_OFFER;
      ST_OFFER:   if (o_ready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ballistics strobe and frame register loads
  always_comb begin
    update_en = 1'b0;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    case (state_q)
      ST_UPDATE: update_en = 1'b1;
      ST_COMPOSE: begin
        o_valid_d = 1'b1;
        o_data_d  = {left_pattern, right_pattern};
      end
      ST_OFFER: if (o_ready) o_valid_d = 1'b0;
      default: ;
    endcase
  end

  // Frame output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

endmodule

// File: tb/tb_meter_frame_scheduler.sv
// Self-checking bench for meter_frame_scheduler with a behavioural frame model.
module tb_meter_frame_scheduler;

  localparam int LEDS  = 16;
  localparam int LW    = 16;
  localparam int DIV   = 8;
  localparam int HOLD  = 3;
  localparam int DECAY = 1;

  logic          clk     = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [LW-1:0] i_left  = '0;
  logic [LW-1:0] i_right = '0;
  logic          o_valid;
  logic          o_ready = 1'b1;
  logic [31:0]   o_data;
  logic          o_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  meter_frame_scheduler #(
    .LEDS             (LEDS),
    .LEVEL_WIDTH      (LW),
    .REFRESH_DIV      (DIV),
    .PEAK_HOLD_FRAMES (HOLD),
    .DECAY_FRAMES     (DECAY)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_valid   (i_valid),
    .i_ready   (i_ready),
    .i_left    (i_left),
    .i_right   (i_right),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_data    (o_data),
    .o_overrun (o_overrun)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_tcnt = 0;
  int          m_ph   = 0;   // 0 waiting, 1 ballistics, 2 compose, 3 offering
  bit          m_tp   = 0;
  bit          m_v    = 0;
  bit          m_ovr  = 0;
  logic [31:0] m_data = '0;
  int          m_bar[2], m_peak[2], m_hold[2], m_dc[2];
  bit          m_got[2], m_raised[2];

  function automatic int lvl2n(input logic [15:0] l);
    int n;
    n = l >> 11;
    if (n > LEDS) n = LEDS;
    return n;
  endfunction

  function automatic logic [15:0] half(input int b, input int p);
    logic [31:0] r;
    r = (32'd1 << b) - 32'd1;
    if (p > 0) r = r | (32'd1 << (p - 1));
    return r[15:0];
  endfunction

  task automatic model_reset();
    m_tcnt = 0; m_ph = 0; m_tp = 0; m_v = 0; m_ovr = 0; m_data = '0;
    for (int c = 0; c < 2; c++) begin
      m_bar[c] = 0; m_peak[c] = 0; m_hold[c] = 0; m_dc[c] = 0;
      m_got[c] = 0; m_raised[c] = 0;
    end
  endtask

  task automatic model_step();
    bit wrap, ntp;
    int n[2];
    wrap   = (m_tcnt == DIV - 1);
    m_ovr  = wrap && m_tp && (m_ph != 1);
    ntp    = (m_tp && (m_ph != 1)) || wrap;
    m_tcnt = wrap ? 0 : m_tcnt + 1;
    n[0]   = lvl2n(i_left);
    n[1]   = lvl2n(i_right);
    case (m_ph)
      0: begin
        if (i_valid) begin
          for (int c = 0; c < 2; c++) begin
            if (n[c] > m_bar[c]) m_bar[c] = n[c];
            if (n[c] > m_peak[c]) begin
              m_peak[c] = n[c]; m_hold[c] = HOLD; m_raised[c] = 1;
            end
            m_got[c] = 1;
          end
        end
        if (m_tp) m_ph = 1;
      end
      1: begin
        for (int c = 0; c < 2; c++) begin
          if (m_got[c]) m_dc[c] = 0;
          else begin
            m_dc[c]++;
            if (m_dc[c] == DECAY) begin
              m_dc[c] = 0;
              if (m_bar[c] > 0) m_bar[c]--;
            end
          end
          if (!m_raised[c]) begin
            if (m_hold[c] > 0) m_hold[c]--;
            else m_peak[c] = (m_peak[c] - 1 > m_bar[c]) ? m_peak[c] - 1 : m_bar[c];
          end
          m_got[c] = 0; m_raised[c] = 0;
        end
        m_ph = 2;
      end
      2: begin
        m_data = {half(m_bar[0], m_peak[0]), half(m_bar[1], m_peak[1])};
        m_v    = 1;
        m_ph   = 3;
      end
      default: begin
        if (o_ready) begin m_v = 0; m_ph = 0; end
      end
    endcase
    m_tp = ntp;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else model_step();
    end
  end

  // Every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        check("rst_o_valid", o_valid, 0);
        check("rst_o_data", o_data, 0);
        check("rst_o_overrun", o_overrun, 0);
        check("rst_i_ready", i_ready, 1);
      end else begin
        check("o_valid", o_valid, m_v);
        check("o_overrun", o_overrun, m_ovr);
        check("i_ready", i_ready, m_ph == 0);
        if (m_v) check("o_data", o_data, m_data);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    #2 reset_n = 1'b0;
    i_valid = 1'b0; i_left = '0; i_right = '0; o_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
  endtask

  task automatic next_frame(output logic [31:0] d, output int cycles);
    int cnt;
    cnt = 0;
    while (o_valid && cnt < 100) begin @(negedge clk); cnt++; end
    while (!o_valid && cnt < 100) begin @(negedge clk); cnt++; end
    check("frame_timeout", cnt < 100, 1);
    d = o_data;
    cycles = cnt;
  endtask

  task automatic send(input logic [15:0] l, input logic [15:0] r);
    i_valid = 1'b1; i_left = l; i_right = r;
    @(negedge clk);
    i_valid = 1'b0; i_left = '0; i_right = '0;
  endtask

  logic [15:0] exp_ball [8] = '{16'h000F, 16'h000F, 16'h000B, 16'h0009,
                                 16'h0004, 16'h0002, 16'h0001, 16'h0000};

  initial begin
    logic [31:0] d;
    int          cyc, ovr, stall;

    // Idle: first frame timing, refresh period, no overruns
    do_reset();
    next_frame(d, cyc);
    check("idle_first_latency", cyc, 11);
    check("idle_first_data", d, 32'h0);
    next_frame(d, cyc);
    check("idle_period", cyc, 8);
    ovr = 0;
    repeat (24) begin @(negedge clk); ovr += o_overrun; end
    check("idle_overrun_count", ovr, 0);

    // Mapping
    do_reset();
    send(16'hFFFF, 16'h0800);
    next_frame(d, cyc);
    check("map_full_and_one", d, 32'hFFFF_0001);
    do_reset();
    send(16'h07FF, 16'h1000);
    next_frame(d, cyc);
    check("map_below_first_led", d, 32'h0000_0003);

    // Ballistics
    do_reset();
    send(16'h2000, 16'h0000);
    for (int k = 0; k < 8; k++) begin
      next_frame(d, cyc);
      check($sformatf("ballistics_%0d", k), d[31:16], exp_ball[k]);
    end

    // Backpressure
    do_reset();
    next_frame(d, cyc);
    o_ready = 1'b0;
    ovr = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      ovr += o_overrun;
      check("stall_valid_held", o_valid, 1);
      check("stall_data_held", o_data, d);
    end
    o_ready = 1'b1;
    @(negedge clk);
    ovr += o_overrun;
    check("stall_overrun_count", ovr, 2);
    cyc = 0;
    while (!o_valid && cyc < 20) begin @(negedge clk); cyc++; end
    check("stall_pending_follows", cyc, 3);

    // Simultaneous input and pending tick
    do_reset();
    repeat (8) @(negedge clk);
    send(16'h2000, 16'hFFFF);
    next_frame(d, cyc);
    check("simul_data", d, 32'h000F_FFFF);
    check("simul_latency", cyc, 2);

    // Reset while a frame is being offered
    do_reset();
    send(16'hFFFF, 16'hFFFF);
    o_ready = 1'b0;
    next_frame(d, cyc);
    check("offer_before_reset", d, 32'hFFFF_FFFF);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("midreset_valid", o_valid, 0);
    check("midreset_data", o_data, 0);
    @(negedge clk);
    #2 reset_n = 1'b1;
    o_ready = 1'b1;
    next_frame(d, cyc);
    check("after_reset_frame", d, 32'h0);

    // Randomized traffic against the model
    do_reset();
    stall = 0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      i_valid = ($urandom_range(0, 3) == 0);
      i_left  = 16'($urandom >> $urandom_range(16, 31));
      i_right = 16'($urandom >> $urandom_range(16, 31));
      if (stall == 0 && $urandom_range(0, 99) == 0) stall = $urandom_range(5, 30);
      o_ready = (stall == 0) && ($urandom_range(0, 3) != 0);
      if (stall > 0) stall--;
      if ($urandom_range(0, 999) == 0) do_reset();
    end
    i_valid = 1'b0;
    o_ready = 1'b1;
    repeat (20) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/meter_frame_scheduler.md
Name: meter_frame_scheduler

Overview:
Sequences the serial LED-driver shifter for the stereo level meter. Accepts left/right audio levels and applies per-channel ballistics: fast attack, stepped decay, peak-hold dot. At a fixed refresh rate it composes a 2*LEDS-bit frame and offers it to the shifter over a valid/ready handshake. Sits between the level detector and the shift-register driver.

Parameters:
LEDS, 16, LEDs per channel; frame width = 2*LEDS
LEVEL_WIDTH, 16, unsigned level input width
REFRESH_DIV, 1000, clk cycles between frame ticks (>=4)
PEAK_HOLD_FRAMES, 50, frames the peak dot is held before falling
DECAY_FRAMES, 2, frames per 1-LED bar decay step (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  reset; asynchronous, active-low
i_valid  in  1  level pair valid
i_ready  out  1  level pair accepted when i_valid&&i_ready
i_left  in  LEVEL_WIDTH  left level, unsigned
i_right  in  LEVEL_WIDTH  right level, unsigned
o_valid  out  1  frame valid to shifter
o_ready  in  1  shifter ready
o_data  out  2*LEDS  frame; [2*LEDS-1:LEDS]=left, [LEDS-1:0]=right; MSB shifted first
o_overrun  out  1  one-cycle pulse when a tick is lost

Behaviour:
- Clock/reset: single clock clk; reset_n asynchronous, active-low. While reset_n=0: o_valid=0, o_data=0, o_overrun=0, state=IDLE, bars/peaks/hold/decay/tick counters=0, tick_pending=0.
- i_ready = (state==IDLE); it is therefore 1 out of reset.
- Level->count: CW=$clog2(LEDS+1); n = level>>(LEVEL_WIDTH-CW), saturated to LEDS. Thermometer: bits [n-1:0] set; n=0 gives 0.
- Tick: counter 0..REFRESH_DIV-1 runs continuously; wrap sets tick_pending. First tick REFRESH_DIV cycles after reset release. Tick while tick_pending already 1 -> o_overrun pulse; tick is dropped (ticks coalesce).
- Input accept (IDLE only): bar = max(bar,n); if n>peak then peak=n, hold=PEAK_HOLD_FRAMES, raised flag set; got_input flag set. Per channel, independent.
- FSM:
  IDLE: if tick_pending -> UPDATE (input in the same cycle is applied first).
  UPDATE (1 cycle): clear tick_pending; per channel: if !got_input, decay counter++, on reaching DECAY_FRAMES reset it and bar -= 1 (floor 0); if got_input, reset decay counter. If !raised: hold>0 ? hold-1 : peak = max(peak-1, bar). Clear flags. -> COMPOSE.
  COMPOSE (1 cycle): o_data <= per-channel thermometer(bar) | (peak>0 ? 1<<(peak-1) : 0); o_valid <= 1 -> OFFER.
  OFFER: hold o_valid, o_data stable until o_ready; on o_valid&&o_ready, o_valid<=0 -> IDLE. If tick_pending set, UPDATE follows IDLE one cycle later.
- Latency: tick to o_valid = 3 cycles when idle.
- Peak never below bar after UPDATE; bars/peaks never exceed LEDS.
- Reset mid-OFFER: o_valid drops asynchronously; no partial frame is retained.

Decomposition:
- Package meter_pkg: FSM state encoding (IDLE, UPDATE, COMPOSE, OFFER), CW function, and the level-to-count saturation function.
- Sub-module meter_channel (instantiated twice): per-channel bar, peak, hold and decay counters, input merge, UPDATE step, LEDS-bit pattern output. Top holds the tick divider, FSM, handshake and overrun logic.

Test Plan (LEDS=16, LEVEL_WIDTH=16, REFRESH_DIV=8, PEAK_HOLD_FRAMES=3, DECAY_FRAMES=1, o_ready=1 unless stated):
- Idle: reset release, no input -> o_valid first high 11 cycles after release with o_data=0; one frame per 8 cycles; o_overrun never pulses.
- Mapping: left=16'hFFFF, right=16'h0800 -> next frame 32'hFFFF_0001; left=16'h07FF -> left half 0.
- Ballistics: one input left=16'h2000 (n=4), then none -> left halves of successive frames 0x000F, 0x000F, 0x000B, 0x0009, 0x0004, 0x0002, 0x0001, 0x0000.
- Backpressure: o_ready=0 for 20 cycles -> o_valid and o_data stable, i_ready=0, o_overrun pulses once per dropped tick. On o_ready=1 the frame completes and the pending frame follows 3 cycles later.
- Simultaneous: input accepted on the same cycle tick_pending is seen in IDLE -> the new level appears in that frame.
- Reset mid-OFFER: reset_n=0 while o_valid=1 -> o_valid=0, o_data=0 immediately; after release the first frame is all zeros.
